// File: rtl/mem_arbiter.sv
// N-port arbiter between the L1 caches and the single physical-memory port.
// One transaction at a time: IDLE samples requests, ACTIVE holds the grant, DONE gives one quiet cycle.
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int RR_MODE    = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             port_read,
  input  logic [NUM_PORTS-1:0]             port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
  output logic [NUM_PORTS-1:0]             port_resp,
  output logic [DATA_WIDTH-1:0]            port_rdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_addr,
  output logic [DATA_WIDTH-1:0]            pmem_wdata,
  input  logic [DATA_WIDTH-1:0]            pmem_rdata,
  input  logic                             pmem_resp,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_id,
  output logic                             busy
);

  localparam int GW = $clog2(NUM_PORTS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [NUM_PORTS-1:0]  req;
  logic                  win_found;
  logic [GW-1:0]         win_idx;
  logic [GW-1:0]         cand_idx;
  int                    cand;
  logic                  resp_hit;

  // Winner search: start at rr_ptr in round-robin mode, at port 0 otherwise, wrapping modulo NUM_PORTS.
  always_comb begin
    req       = port_read | port_write;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (RR_MODE != 0) ? int'(rr_ptr_q) + k : k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = GW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_ACTIVE;
          grant_d = win_idx;
          // A port asserting both read and write is served as a write only.
          wr_d    = port_write[win_idx];
          rd_d    = ~port_write[win_idx];
          addr_d  = port_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = port_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      S_ACTIVE: begin
        if (pmem_resp) begin
          state_d  = S_DONE;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          rr_ptr_d = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Memory completion is forwarded in the same cycle, and only to the granted port.
  assign resp_hit = (state_q == S_ACTIVE) && pmem_resp;

  always_comb begin
    port_resp = '0;
    if (resp_hit) port_resp[grant_q] = 1'b1;
  end

  assign port_rdata = resp_hit ? pmem_rdata : '0;
  assign pmem_read  = rd_q;
  assign pmem_write = wr_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 2-port fixed-priority instance driven from a vector table,
// and a 4-port round-robin instance checked against a pointer-based reference model.
module tb_mem_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2-port fixed-priority instance
  logic         rst0;
  logic [1:0]   p0_read, p0_write, p0_resp;
  logic [63:0]  p0_addr;
  logic [511:0] p0_wdata;
  logic [255:0] p0_rdata, m0_wdata, m0_rdata;
  logic         m0_read, m0_write, m0_resp, busy0;
  logic [31:0]  m0_addr;
  logic [0:0]   g0;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(256), .RR_MODE(0)) u_fp (
    .clk(clk), .reset(rst0), .port_read(p0_read), .port_write(p0_write),
    .port_addr(p0_addr), .port_wdata(p0_wdata), .port_resp(p0_resp), .port_rdata(p0_rdata),
    .pmem_read(m0_read), .pmem_write(m0_write), .pmem_addr(m0_addr), .pmem_wdata(m0_wdata),
    .pmem_rdata(m0_rdata), .pmem_resp(m0_resp), .grant_id(g0), .busy(busy0));

  // 4-port round-robin instance
  logic         rst1;
  logic [3:0]   p1_read, p1_write, p1_resp;
  logic [127:0] p1_addr, p1_wdata;
  logic [31:0]  p1_rdata, m1_addr, m1_wdata, m1_rdata;
  logic         m1_read, m1_write, m1_resp, busy1;
  logic [1:0]   g1;

  mem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(rst1), .port_read(p1_read), .port_write(p1_write),
    .port_addr(p1_addr), .port_wdata(p1_wdata), .port_resp(p1_resp), .port_rdata(p1_rdata),
    .pmem_read(m1_read), .pmem_write(m1_write), .pmem_addr(m1_addr), .pmem_wdata(m1_wdata),
    .pmem_rdata(m1_rdata), .pmem_resp(m1_resp), .grant_id(g1), .busy(busy1));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] a0, a1;
    logic [7:0]  wd0, wd1;
    int          lat;
    logic [7:0]  rb;
    int          exp_win;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [7:0]  exp_wd;
  } vec_t;

  // One full transaction on the fixed-priority instance; entered and left on a negedge in IDLE.
  task automatic txn0(input vec_t v, input bit drop);
    p0_read  = v.rd;
    p0_write = v.wr;
    p0_addr  = {v.a1, v.a0};
    p0_wdata = {{32{v.wd1}}, {32{v.wd0}}};
    m0_resp  = 1'b0;
    m0_rdata = {32{8'hC3}};
    @(negedge clk);
    chk("fp_grant", 256'(g0), 256'(v.exp_win));
    chk("fp_busy_active", 256'(busy0), 256'(1));
    chk("fp_resp_early", {p0_resp, p0_rdata}, '0);
    chk("fp_wdata", m0_wdata, {32{v.exp_wd}});
    if (drop) begin
      p0_read  = 2'b00;
      p0_write = 2'b00;
    end
    for (int c = 1; c < v.lat; c++) begin
      chk("fp_cmd_hold", 256'({m0_read, m0_write, m0_addr}), 256'({~v.exp_wr, v.exp_wr, v.exp_addr}));
      @(negedge clk);
    end
    chk("fp_cmd_last", 256'({m0_read, m0_write, m0_addr}), 256'({~v.exp_wr, v.exp_wr, v.exp_addr}));
    m0_resp  = 1'b1;
    m0_rdata = {32{v.rb}};
    #1;
    chk("fp_port_resp", 256'(p0_resp), 256'(2'b01 << v.exp_win));
    chk("fp_port_rdata", p0_rdata, {32{v.rb}});
    @(negedge clk);
    // pmem_resp left high into DONE must be ignored
    chk("fp_done", 256'({busy0, m0_read, m0_write, p0_resp}), 256'({1'b1, 4'b0000}));
    chk("fp_done_rdata", p0_rdata, '0);
    m0_resp = 1'b0;
    p0_read[v.exp_win]  = 1'b0;
    p0_write[v.exp_win] = 1'b0;
    @(negedge clk);
    chk("fp_idle", 256'(busy0), 256'(0));
  endtask

  // One full transaction on the round-robin instance with random addresses and data.
  task automatic txn1(input logic [3:0] rd, input logic [3:0] wr, input int lat,
                      input int exp_win, input logic exp_wr);
    logic [31:0] aa [4];
    logic [31:0] ww [4];
    logic [31:0] rb;
    for (int i = 0; i < 4; i++) begin
      aa[i] = $urandom;
      ww[i] = $urandom;
      p1_addr[i*32 +: 32]  = aa[i];
      p1_wdata[i*32 +: 32] = ww[i];
    end
    p1_read  = rd;
    p1_write = wr;
    m1_resp  = 1'b0;
    m1_rdata = $urandom;
    @(negedge clk);
    chk("rr_grant", 256'(g1), 256'(exp_win));
    chk("rr_cmd", 256'({m1_read, m1_write}), 256'({~exp_wr, exp_wr}));
    chk("rr_addr_data", 256'({m1_addr, m1_wdata}), 256'({aa[exp_win], ww[exp_win]}));
    repeat (lat - 1) @(negedge clk);
    rb       = $urandom;
    m1_resp  = 1'b1;
    m1_rdata = rb;
    #1;
    chk("rr_port_resp", 256'(p1_resp), 256'(4'b0001 << exp_win));
    chk("rr_port_rdata", 256'(p1_rdata), 256'(rb));
    @(negedge clk);
    chk("rr_done", 256'({busy1, m1_read, m1_write, p1_resp, p1_rdata}), 256'({1'b1, 38'd0}));
    m1_resp = 1'b0;
    @(negedge clk);
    chk("rr_idle", 256'(busy1), 256'(0));
  endtask

  // Reference: first requester at or after the pointer, scanning modulo the port count.
  function automatic int rr_pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++)
      if (((req >> ((ptr + k) % 4)) & 4'd1) != 4'd0) return (ptr + k) % 4;
    return -1;
  endfunction

  vec_t tbl [8];
  int   ptr;
  int   w;
  logic [3:0] rq, wq;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    p0_read = '0; p0_write = '0; p0_addr = '0; p0_wdata = '0; m0_rdata = '0; m0_resp = 1'b0;
    p1_read = '0; p1_write = '0; p1_addr = '0; p1_wdata = '0; m1_rdata = '0; m1_resp = 1'b0;

    tbl[0] = '{2'b01, 2'b00, 32'h0000_1000, 32'h0, 8'h00, 8'h00, 4, 8'hA5, 0, 1'b0, 32'h0000_1000, 8'h00};
    for (int r = 0; r < 3; r++) begin
      tbl[1+2*r] = '{2'b01, 2'b10, 32'h100, 32'h200, 8'h11, 8'h3C, 2 + r, 8'h5A + 8'(r), 0, 1'b0, 32'h100, 8'h11};
      tbl[2+2*r] = '{2'b00, 2'b10, 32'h100, 32'h200, 8'h11, 8'h3C, 3, 8'h77, 1, 1'b1, 32'h200, 8'h3C};
    end
    tbl[7] = '{2'b10, 2'b10, 32'h40, 32'h300, 8'h01, 8'hDE, 2, 8'h99, 1, 1'b1, 32'h300, 8'hDE};

    #2;
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("rst_fp", {busy0, m0_read, m0_write, g0, p0_resp, m0_addr}, '0);
    chk("rst_fp_data", m0_wdata | p0_rdata, '0);
    chk("rst_rr", 256'({busy1, m1_read, m1_write, g1, p1_resp, m1_addr, m1_wdata}), '0);
    @(negedge clk);
    rst0 = 1'b1; rst1 = 1'b1;

    // Fixed-priority vector table
    for (int i = 0; i < 8; i++) txn0(tbl[i], 1'b0);

    // Spurious memory response while IDLE
    m0_resp = 1'b1;
    m0_rdata = {32{8'hFF}};
    #1;
    chk("spur_resp", {254'(p0_resp), 2'b00} | 256'(busy0), '0);
    chk("spur_rdata", p0_rdata, '0);
    @(negedge clk);
    m0_resp = 1'b0;
    chk("spur_idle", 256'({busy0, m0_read, m0_write}), '0);

    // Request dropped right after the grant still completes
    txn0('{2'b10, 2'b00, 32'h0, 32'h0000_0ABC, 8'h00, 8'h42, 3, 8'h6B, 1, 1'b0, 32'h0000_0ABC, 8'h42}, 1'b1);

    // Round-robin fairness with all four ports requesting
    ptr = 0;
    for (int k = 0; k < 6; k++) begin
      txn1(4'b1111, 4'b0000, 1 + (k % 3), k % 4, 1'b0);
      ptr = (k % 4 + 1) % 4;
    end

    // Random request patterns against the reference model
    for (int t = 0; t < 20; t++) begin
      rq = 4'($urandom_range(0, 15));
      wq = 4'($urandom_range(0, 15));
      if ((rq | wq) == 4'd0) rq = 4'd1 << (t % 4);
      w = rr_pick(rq | wq, ptr);
      txn1(rq, wq, $urandom_range(1, 5), w, wq[w[1:0]]);
      ptr = (w + 1) % 4;
    end

    // Leave the pointer at 2, then reset in the middle of a transaction
    w = rr_pick(4'b0010, ptr);
    txn1(4'b0010, 4'b0000, 2, w, 1'b0);
    ptr = (w + 1) % 4;
    p1_read = 4'b0100;
    p1_write = 4'b0000;
    @(negedge clk);
    chk("rr_pre_reset_grant", 256'(g1), 256'(rr_pick(4'b0100, ptr)));
    @(negedge clk);
    @(negedge clk);
    m1_resp = 1'b1;
    rst1 = 1'b0;
    #1;
    chk("rst_mid", 256'({busy1, m1_read, m1_write, g1, p1_resp, p1_rdata}), '0);
    chk("rst_mid_data", 256'({m1_addr, m1_wdata}), '0);
    @(negedge clk);
    m1_resp = 1'b0;
    p1_read = 4'b0000;
    @(negedge clk);
    rst1 = 1'b1;
    ptr = 0;
    w = rr_pick(4'b1010, ptr);
    txn1(4'b1010, 4'b0000, 2, w, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-port arbiter between the L1 caches (instruction, data, and any future prefetch/victim ports) and the single physical-memory port. It samples requests when idle, grants one port by fixed-priority or round-robin policy, latches that port's address, command and write data, and holds the grant until memory responds. The response is then routed back to the granted port only, and all other ports see an idle response.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesting ports (≥2); port 0 = instruction cache, port 1 = data cache
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 256, line width carried on rdata/wdata
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- port_read  in  NUM_PORTS  per-port read request, held until port_resp
- port_write  in  NUM_PORTS  per-port write request, held until port_resp
- port_addr  in  NUM_PORTS×ADDR_WIDTH  per-port address
- port_wdata  in  NUM_PORTS×DATA_WIDTH  per-port write data
- port_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse
- port_rdata  out  DATA_WIDTH  shared read-data bus, valid with port_resp
- pmem_read  out  1  memory read command
- pmem_write  out  1  memory write command
- pmem_addr  out  ADDR_WIDTH  latched address
- pmem_wdata  out  DATA_WIDTH  latched write data
- pmem_rdata  in  DATA_WIDTH  memory read data
- pmem_resp  in  1  memory completion, one cycle
- grant_id  out  $clog2(NUM_PORTS)  index of current/last grant
- busy  out  1  high in ACTIVE and DONE

## Operation
- FSM states: IDLE, ACTIVE, DONE.
- IDLE: request vector req[i] = port_read[i] | port_write[i]. If any bit is set, select winner, latch addr, wdata and command, set grant_id, go to ACTIVE. Otherwise stay.
- Fixed priority: lowest set index wins.
- Round-robin: search starts at pointer rr_ptr and wraps modulo NUM_PORTS. After each completion, rr_ptr = grant_id+1, wrapping NUM_PORTS-1 → 0.
- Port with both read and write set: treated as write. Read is not performed.
- ACTIVE: pmem_read/pmem_write driven from the latched command; pmem_addr/pmem_wdata stable. On pmem_resp: port_resp[grant_id]=1 in that cycle, port_rdata = pmem_rdata (combinational pass), go to DONE.
- DONE: commands low for one cycle so the requester can drop its request. Then go to IDLE.
- Requests arriving or changing in ACTIVE/DONE are ignored until IDLE.
- A request dropped mid-ACTIVE does not abort the transaction. The memory access completes and port_resp still pulses.
- port_rdata = 0 whenever no port_resp is asserted.
- port_resp bits of non-granted ports are always 0.

## Timing
- Reset (asserted low, any cycle, asynchronous): state=IDLE, rr_ptr=0, grant_id=0, pmem_read=pmem_write=0, pmem_addr=0, pmem_wdata=0, port_resp=0, busy=0. An in-flight memory access is abandoned.
- Latency:
  - request seen in IDLE at edge n → pmem command high from cycle n+1
  - pmem_resp at cycle k → port_resp at cycle k (0 added cycles)
  - DONE at k+1, IDLE at k+2
  - next grant's command from k+3
- Minimum occupancy per transaction: 3 cycles plus memory latency.
- pmem_read/pmem_write are registered outputs and never both high.
- pmem_resp while IDLE or DONE is ignored. No port_resp is generated.

## Test plan
- Single read, port 0: port_read=01, addr 0x0000_1000; memory responds 4 cycles later with rdata=0xA5…A5 → pmem_read high 1 cycle after request, port_resp=01 in the pmem_resp cycle with 0xA5…A5, busy low 2 cycles later.
- Simultaneous requests, RR_MODE=0: port 0 read 0x100 and port 1 write 0x200 held together → port 0 served first, then port 1 write with pmem_wdata = port 1 data. Repeat three times; port 0 always wins.
- Round-robin fairness, RR_MODE=1, NUM_PORTS=4: all four request continuously → grant_id sequence 0,1,2,3,0,1, with wrap 3→0 checked.
- Read+write both set on port 1, data 0xDEAD… → only pmem_write asserted, never pmem_read.
- Reset mid-ACTIVE: reset low 2 cycles after grant → all outputs zero immediately. After reset release, a new request on port 1 is granted with rr_ptr=0 behaviour.
- Request dropped during ACTIVE, plus spurious pmem_resp in IDLE → transaction completes with port_resp pulse; spurious resp produces no port_resp.
